// File: rtl/mca_pkg.sv
// mca_pkg: shared state encoding and slice width for the multi-cycle adder
package mca_pkg;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN = 2'b01;
  localparam logic [1:0] DONE = 2'b10;
  localparam int SLICE_W = 2;
endpackage

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: 2-bit ripple slice built from two chained full adders
module ripple_carry_adder (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  input  logic       c_i,
  output logic [1:0] s_o,
  output logic       c_o
);
  logic c1;
  assign s_o[0] = a_i[0] ^ b_i[0] ^ c_i;
  assign c1 = (a_i[0] & b_i[0]) | (c_i & (a_i[0] ^ b_i[0]));
  assign s_o[1] = a_i[1] ^ b_i[1] ^ c1;
  assign c_o = (a_i[1] & b_i[1]) | (c1 & (a_i[1] ^ b_i[1]));
endmodule

// File: rtl/multi_cycle_adder.sv
// multi_cycle_adder: WIDTH-bit add done two bits per cycle through one ripple slice
// Optional output_OVF port enabled by defining MULTI_CYCLE_ADDER_OVERFLOW_EN
module multi_cycle_adder
  import mca_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             input_CLK,
  input  logic             input_RST,
  input  logic             input_START,
  input  logic [WIDTH-1:0] input_A,
  input  logic [WIDTH-1:0] input_B,
  input  logic             input_C0,
  output logic [WIDTH-1:0] output_S,
  output logic             output_C,
  output logic             output_BUSY,
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
  output logic             output_OVF,
`endif
  output logic             output_DONE
);
  localparam int IW = $clog2(WIDTH);
  localparam int NS = WIDTH / SLICE_W;
  logic [1:0] state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic cy_q, cy_d, c_q, c_d;
  logic [SLICE_W-1:0] sl_s;
  logic sl_c, last;
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
  logic ovf_q, ovf_d;
  assign output_OVF = ovf_q;
`endif
  assign last = idx_q == IW'(NS - 1);
  ripple_carry_adder u_rca (
    .a_i(a_q[int'(idx_q)*SLICE_W +: SLICE_W]),
    .b_i(b_q[int'(idx_q)*SLICE_W +: SLICE_W]),
    .c_i(cy_q),
    .s_o(sl_s),
    .c_o(sl_c)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    a_d = a_q;
    b_d = b_q;
    s_d = s_q;
    cy_d = cy_q;
    c_d = c_q;
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
    ovf_d = ovf_q;
`endif
    if (state_q == IDLE && input_START) begin
      a_d = input_A;
      b_d = input_B;
      cy_d = input_C0;
      idx_d = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      s_d[int'(idx_q)*SLICE_W +: SLICE_W] = sl_s;
      cy_d = sl_c;
      idx_d = idx_q + IW'(1);
      if (last) begin
        state_d = DONE;
        c_d = sl_c;
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
        ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_s[SLICE_W-1] != a_q[WIDTH-1]);
`endif
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge input_CLK) begin
    if (input_RST) begin
      state_q <= IDLE;
      idx_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      cy_q <= 1'b0;
      c_q <= 1'b0;
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      cy_q <= cy_d;
      c_q <= c_d;
`ifdef MULTI_CYCLE_ADDER_OVERFLOW_EN
      ovf_q <= ovf_d;
`endif
    end
  end
  assign output_S = s_q;
  assign output_C = c_q;
  assign output_BUSY = state_q != IDLE;
  assign output_DONE = state_q == DONE;
endmodule
